// File: rtl/bus_mem_responder_if.sv
// Bus-side request/response bundle between an L1 bus master and the memory responder.
// The master drives requests; the slave (responder) returns per-beat MEM_RESP.
interface bus_mem_responder_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 32,
    parameter int MSG_BITS        = 4,
    parameter int BUS_OFFSET_BITS = 0,
    parameter int MAX_OFFSET_BITS = 3
);
    localparam int BUS_WIDTH = DATA_WIDTH << BUS_OFFSET_BITS;
    localparam int OFF_W     = $clog2(MAX_OFFSET_BITS) + 1;

    logic [MSG_BITS-1:0]     bus_msg_in;
    logic [ADDRESS_BITS-1:0] bus_address_in;
    logic [BUS_WIDTH-1:0]    bus_data_in;
    logic [OFF_W-1:0]        req_offset;
    logic [MSG_BITS-1:0]     bus_msg_out;
    logic [BUS_WIDTH-1:0]    bus_data_out;
    logic                    bus_last;
    logic                    req_ready;

    modport master (
        output bus_msg_in, bus_address_in, bus_data_in, req_offset,
        input  bus_msg_out, bus_data_out, bus_last, req_ready
    );

    modport slave (
        input  bus_msg_in, bus_address_in, bus_data_in, req_offset,
        output bus_msg_out, bus_data_out, bus_last, req_ready
    );
endinterface

// File: rtl/bus_mem_responder.sv
// Memory-side bus responder: serves line reads and write-backs beat by beat
// against a word-addressed backing memory, one MEM_RESP per completed beat.
module bus_mem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 32,
    parameter int MSG_BITS        = 4,
    parameter int BUS_OFFSET_BITS = 0,
    parameter int MAX_OFFSET_BITS = 3,
    parameter logic [MSG_BITS-1:0] NO_REQ   = MSG_BITS'(0),
    parameter logic [MSG_BITS-1:0] R_REQ    = MSG_BITS'(1),
    parameter logic [MSG_BITS-1:0] WB_REQ   = MSG_BITS'(2),
    parameter logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(8)
) (
    input  logic                                         clock,
    input  logic                                         reset,
    bus_mem_responder_if.slave                           bus,
    output logic                                         mem_read,
    output logic                                         mem_write,
    output logic [ADDRESS_BITS-1:0]                      mem_address,
    output logic [(DATA_WIDTH<<BUS_OFFSET_BITS)-1:0]     mem_data_out,
    input  logic [(DATA_WIDTH<<BUS_OFFSET_BITS)-1:0]     mem_data_in,
    input  logic                                         mem_valid
);
    localparam int BUS_WIDTH = DATA_WIDTH << BUS_OFFSET_BITS;
    localparam int OFF_W     = $clog2(MAX_OFFSET_BITS) + 1;
    localparam int CNT_W     = MAX_OFFSET_BITS + 1;

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_ACK, WR_LOAD, DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        beat_q, beat_d;
    logic [OFF_W-1:0]        eo_q, eo_d;
    logic [ADDRESS_BITS-1:0] base_q, base_d;
    logic [MSG_BITS-1:0]     msg_out_q, msg_out_d;
    logic [BUS_WIDTH-1:0]    data_out_q, data_out_d;
    logic                    last_q, last_d;
    logic                    ready_q, ready_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]    wdata_q, wdata_d;

    logic [OFF_W-1:0]        req_eo;
    logic [ADDRESS_BITS-1:0] req_base;
    logic [CNT_W-1:0]        last_idx;
    logic [CNT_W-1:0]        next_beat;
    logic [ADDRESS_BITS-1:0] next_addr;
    logic                    final_beat;

    // Requests larger than the supported line are clamped, not rejected.
    always_comb begin
        req_eo   = (bus.req_offset > OFF_W'(MAX_OFFSET_BITS)) ? OFF_W'(MAX_OFFSET_BITS)
                                                              : bus.req_offset;
        req_base = bus.bus_address_in
                   & ~((ADDRESS_BITS'(1) << req_eo) - ADDRESS_BITS'(1));
        if (eo_q > OFF_W'(BUS_OFFSET_BITS))
            last_idx = CNT_W'((32'd1 << (eo_q - OFF_W'(BUS_OFFSET_BITS))) - 32'd1);
        else
            last_idx = '0;
        final_beat = (beat_q == last_idx);
        next_beat  = beat_q + CNT_W'(1);
        next_addr  = base_q + (ADDRESS_BITS'(next_beat) << BUS_OFFSET_BITS);
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        eo_d       = eo_q;
        base_d     = base_q;
        msg_out_d  = NO_REQ;
        data_out_d = data_out_q;
        last_d     = 1'b0;
        ready_d    = ready_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.bus_msg_in == R_REQ || bus.bus_msg_in == WB_REQ) begin
                    eo_d    = req_eo;
                    base_d  = req_base;
                    beat_d  = '0;
                    addr_d  = req_base;
                    ready_d = 1'b0;
                    if (bus.bus_msg_in == R_REQ) begin
                        rd_d    = 1'b1;
                        state_d = RD_WAIT;
                    end else begin
                        wr_d    = 1'b1;
                        wdata_d = bus.bus_data_in;
                        state_d = WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (mem_valid) begin
                    msg_out_d  = MEM_RESP;
                    data_out_d = mem_data_in;
                    last_d     = final_beat;
                    state_d    = RD_RESP;
                end
            end
            RD_RESP: begin
                if (final_beat) begin
                    state_d = DONE;
                end else begin
                    beat_d  = next_beat;
                    addr_d  = next_addr;
                    rd_d    = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            WR_WAIT: begin
                if (mem_valid) begin
                    msg_out_d = MEM_RESP;
                    last_d    = final_beat;
                    state_d   = WR_ACK;
                end
            end
            WR_ACK: begin
                if (final_beat) begin
                    state_d = DONE;
                end else begin
                    beat_d  = next_beat;
                    addr_d  = next_addr;
                    state_d = WR_LOAD;
                end
            end
            // The master has had a cycle to present the next beat's data.
            WR_LOAD: begin
                wr_d    = 1'b1;
                wdata_d = bus.bus_data_in;
                state_d = WR_WAIT;
            end
            DONE: begin
                if (bus.bus_msg_in == NO_REQ) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            eo_q       <= '0;
            base_q     <= '0;
            msg_out_q  <= NO_REQ;
            data_out_q <= '0;
            last_q     <= 1'b0;
            ready_q    <= 1'b1;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            eo_q       <= eo_d;
            base_q     <= base_d;
            msg_out_q  <= msg_out_d;
            data_out_q <= data_out_d;
            last_q     <= last_d;
            ready_q    <= ready_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.bus_msg_out  = msg_out_q;
    assign bus.bus_data_out = data_out_q;
    assign bus.bus_last     = last_q;
    assign bus.req_ready    = ready_q;
    assign mem_read         = rd_q;
    assign mem_write        = wr_q;
    assign mem_address      = addr_q;
    assign mem_data_out     = wdata_q;
endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: latency-L memory model, read/write-back
// transactions, offset clamping, held requests, mid-transfer reset.
module tb_bus_mem_responder;
  localparam int AW = 32;
  localparam int BW = 32;
  localparam logic [3:0] NO_REQ = 4'd0, R_REQ = 4'd1, WB_REQ = 4'd2, MEM_RESP = 4'd8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_data_out;
  logic [BW-1:0] mem_data_in = '0;
  logic mem_valid = 1'b0;

  bus_mem_responder_if bif();

  bus_mem_responder dut (
    .clock(clock), .reset(reset), .bus(bif),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_valid(mem_valid)
  );

  always #5 clock = ~clock;

  // Memory model: mem_valid arrives lat cycles after the strobe cycle (lat=0: same cycle).
  logic [31:0] mem_arr [0:255];
  int lat = 2;
  bit pend = 0;
  bit pwr = 0;
  int cnt = 0;
  logic [AW-1:0] paddr = '0;

  always @(negedge clock) begin
    mem_valid = 1'b0;
    if (mem_read || mem_write) begin
      pend = 1; pwr = mem_write; paddr = mem_address; cnt = lat;
    end
    if (pend) begin
      if (cnt == 0) begin
        mem_valid = 1'b1;
        if (!pwr) mem_data_in = mem_arr[paddr[7:0]];
        pend = 0;
      end else cnt--;
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  int rd_cyc[$]; logic [31:0] rd_adr[$];
  int wr_cyc[$]; logic [31:0] wr_adr[$]; logic [31:0] wr_dat[$];
  int rs_cyc[$]; logic [31:0] rs_dat[$]; logic rs_lst[$];
  int nr_cyc, rdy_cyc, rdy_early;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction; cycle 0 is the cycle the request is first presented.
  task automatic txn(input logic [3:0] msg, input logic [31:0] addr, input logic [2:0] off,
                     input logic [31:0] d0, input logic [31:0] d1, input int hold);
    int c; int after; bit done;
    rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
    rs_cyc.delete(); rs_dat.delete(); rs_lst.delete();
    nr_cyc = -1; rdy_cyc = -1; rdy_early = 0;
    @(posedge clock); #1;
    bif.bus_msg_in = msg; bif.bus_address_in = addr; bif.req_offset = off; bif.bus_data_in = d0;
    c = 0; after = -1; done = 0;
    while (!done && c < 300) begin
      @(negedge clock);
      if (c == 0) chk("ready_c0", bif.req_ready, 1);
      if (mem_read) begin rd_cyc.push_back(c); rd_adr.push_back(mem_address); end
      if (mem_write) begin
        wr_cyc.push_back(c); wr_adr.push_back(mem_address); wr_dat.push_back(mem_data_out);
      end
      if (bif.bus_msg_out == MEM_RESP) begin
        rs_cyc.push_back(c); rs_dat.push_back(bif.bus_data_out); rs_lst.push_back(bif.bus_last);
        if (bif.bus_last) after = 0;
        else if (msg == WB_REQ) bif.bus_data_in = d1;
      end
      if (c > 0 && bif.req_ready) begin
        if (nr_cyc >= 0) begin rdy_cyc = c; done = 1; end
        else rdy_early++;
      end
      if (!done) begin
        @(posedge clock); #1;
        c++;
        if (after >= 0) begin
          if (after == hold) begin bif.bus_msg_in = NO_REQ; nr_cyc = c; after = -2; end
          else after++;
        end
      end
    end
    chk("txn_timeout", 32'(done), 1);
    chk("ready_low_busy", rdy_early, 0);
    chk("ready_return", rdy_cyc, nr_cyc + 1);
  endtask

  task automatic chk_read(input string t, input int n, input int per,
                          input logic [31:0] abase, input logic [31:0] dbase);
    chk({t, "_nrd"}, rd_cyc.size(), n);
    chk({t, "_nrs"}, rs_cyc.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rd_cyc.size()) begin
        chk($sformatf("%s_rdcyc%0d", t, i), rd_cyc[i], 1 + per * i);
        chk($sformatf("%s_rdadr%0d", t, i), rd_adr[i], abase + 32'(i));
      end
      if (i < rs_cyc.size()) begin
        chk($sformatf("%s_rscyc%0d", t, i), rs_cyc[i], per + per * i);
        chk($sformatf("%s_rsdat%0d", t, i), rs_dat[i], dbase + 32'(i));
        chk($sformatf("%s_last%0d", t, i), 32'(rs_lst[i]), 32'(i == n - 1));
      end
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h100 + 32'(i);
    for (int i = 0; i < 8; i++) mem_arr[8'h40 + i] = 32'hA0 + 32'(i);
    bif.bus_msg_in = NO_REQ; bif.bus_address_in = '0; bif.bus_data_in = '0; bif.req_offset = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_msg", bif.bus_msg_out, NO_REQ);
    chk("rst_ready", bif.req_ready, 1);
    chk("rst_last", bif.bus_last, 0);
    chk("rst_rd", mem_read, 0);
    chk("rst_wr", mem_write, 0);
    chk("rst_addr", mem_address, 0);
    @(posedge clock); #1; reset = 1'b1;

    txn(R_REQ, 32'h40, 3'd2, 0, 0, 0);
    chk_read("rd4", 4, 4, 32'h40, 32'hA0);
    chk("rd4_rdy", rdy_cyc, 18);

    txn(R_REQ, 32'h46, 3'd2, 0, 0, 0);
    chk_read("rd4u", 4, 4, 32'h44, 32'hA4);

    txn(R_REQ, 32'h46, 3'd0, 0, 0, 0);
    chk_read("rd1", 1, 4, 32'h46, 32'hA6);

    txn(R_REQ, 32'h43, 3'd5, 0, 0, 0);
    chk_read("rd8", 8, 4, 32'h40, 32'hA0);

    txn(WB_REQ, 32'h80, 3'd1, 32'h11, 32'h22, 0);
    chk("wb_nwr", wr_cyc.size(), 2);
    chk("wb_nrs", rs_cyc.size(), 2);
    chk("wb_nrd", rd_cyc.size(), 0);
    if (wr_cyc.size() == 2) begin
      chk("wb_cyc0", wr_cyc[0], 1);  chk("wb_cyc1", wr_cyc[1], 6);
      chk("wb_adr0", wr_adr[0], 32'h80); chk("wb_adr1", wr_adr[1], 32'h81);
      chk("wb_dat0", wr_dat[0], 32'h11); chk("wb_dat1", wr_dat[1], 32'h22);
    end
    if (rs_cyc.size() == 2) begin
      chk("wb_rs0", rs_cyc[0], 4); chk("wb_rs1", rs_cyc[1], 9);
      chk("wb_last0", 32'(rs_lst[0]), 0); chk("wb_last1", 32'(rs_lst[1]), 1);
    end
    chk("wb_rdy", rdy_cyc, 11);

    // Request held 3 cycles past bus_last must not be serviced again.
    txn(R_REQ, 32'h40, 3'd1, 0, 0, 3);
    chk_read("hold", 2, 4, 32'h40, 32'hA0);
    chk("hold_rdy", rdy_cyc, 13);

    // Reset while the second of four reads is outstanding.
    @(posedge clock); #1;
    bif.bus_msg_in = R_REQ; bif.bus_address_in = 32'h40; bif.req_offset = 3'd2;
    n = 0;
    for (int k = 0; k < 60 && n < 2; k++) begin
      @(negedge clock);
      if (mem_read) n++;
    end
    chk("rst_reach", n, 2);
    #1 reset = 1'b0;
    #1;
    chk("mrst_msg", bif.bus_msg_out, NO_REQ);
    chk("mrst_data", bif.bus_data_out, 0);
    chk("mrst_last", bif.bus_last, 0);
    chk("mrst_ready", bif.req_ready, 1);
    chk("mrst_rd", mem_read, 0);
    chk("mrst_wr", mem_write, 0);
    chk("mrst_addr", mem_address, 0);
    chk("mrst_wdata", mem_data_out, 0);
    bif.bus_msg_in = NO_REQ;
    @(posedge clock); #1; reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk($sformatf("late_msg%0d", k), bif.bus_msg_out, NO_REQ);
      chk($sformatf("late_rd%0d", k), 32'(mem_read), 0);
      chk($sformatf("late_rdy%0d", k), bif.req_ready, 1);
    end
    txn(R_REQ, 32'h40, 3'd2, 0, 0, 0);
    chk_read("post", 4, 4, 32'h40, 32'hA0);

    lat = 0;
    txn(R_REQ, 32'h40, 3'd1, 0, 0, 0);
    chk_read("l0", 2, 2, 32'h40, 32'hA0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
